// File: rtl/tmds_word_align.sv
// TMDS word aligner: per-channel phase/bit-slip search driven by control-token density.
module tmds_word_align #(
    parameter int unsigned NCH        = 3,
    parameter int unsigned PHASE_W    = 4,
    parameter int unsigned WIN_LEN    = 1024,
    parameter int unsigned MIN_TOK    = 8,
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned LOSS_WIN   = 2
) (
    input  logic                     clkx1in,
    input  logic                     rstn,
    input  logic                     en,
    input  logic                     restart,
    input  logic [NCH*10-1:0]        rawdata,
    output logic [NCH*10-1:0]        aligned_data,
    output logic [NCH*PHASE_W-1:0]   phasel,
    output logic [NCH-1:0]           ch_locked,
    output logic                     all_locked,
    output logic [NCH-1:0]           sweep_fail
);

    localparam int unsigned SLIP_W = 4;
    localparam int unsigned SET_W  = $clog2(SETTLE_CYC + 1);
    localparam int unsigned WIN_W  = $clog2(WIN_LEN + 1);
    localparam int unsigned TOK_W  = $clog2(MIN_TOK + 1);
    localparam int unsigned LOSS_W = $clog2(LOSS_WIN + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SEARCH = 2'd2,
        LOCKED = 2'd3
    } state_t;

    state_t               state_q    [NCH];
    state_t               state_d    [NCH];
    logic [SET_W-1:0]     set_q      [NCH];
    logic [SET_W-1:0]     set_d      [NCH];
    logic [WIN_W-1:0]     win_q      [NCH];
    logic [WIN_W-1:0]     win_d      [NCH];
    logic [TOK_W-1:0]     tok_q      [NCH];
    logic [TOK_W-1:0]     tok_d      [NCH];
    logic [TOK_W-1:0]     tok_nx     [NCH];
    logic [LOSS_W-1:0]    loss_q     [NCH];
    logic [LOSS_W-1:0]    loss_d     [NCH];
    logic [PHASE_W-1:0]   phase_q    [NCH];
    logic [PHASE_W-1:0]   phase_d    [NCH];
    logic [SLIP_W-1:0]    slip_q     [NCH];
    logic [SLIP_W-1:0]    slip_d     [NCH];
    logic [PHASE_W-1:0]   adv_phase  [NCH];
    logic [SLIP_W-1:0]    adv_slip   [NCH];
    logic                 adv_wrap   [NCH];
    logic [9:0]           raw_prev_q [NCH];
    logic [9:0]           aligned_q  [NCH];
    logic [9:0]           aligned_d  [NCH];
    logic [NCH-1:0]       locked_d;
    logic [NCH-1:0]       fail_d;

    // Any of the four TMDS control-period characters.
    function automatic logic is_tok(input logic [9:0] w);
        return (w == 10'b1101010100) || (w == 10'b0010101011) ||
               (w == 10'b0101010100) || (w == 10'b1010101011);
    endfunction

    // Drive the packed output buses from the per-channel registers.
    for (genvar g = 0; g < int'(NCH); g++) begin : g_out
        assign aligned_data[g*10 +: 10]       = aligned_q[g];
        assign phasel[g*PHASE_W +: PHASE_W]   = phase_q[g];
    end

    // Bit-slip selector: pick 10 bits out of {current, previous} raw words.
    always_comb begin
        for (int i = 0; i < int'(NCH); i++) begin
            aligned_d[i] = 10'({rawdata[10*i +: 10], raw_prev_q[i]} >> slip_q[i]);
        end
    end

    // Next search position: step slip, carry into phase, flag a full sweep on wrap.
    always_comb begin
        for (int i = 0; i < int'(NCH); i++) begin
            adv_slip[i]  = slip_q[i] + SLIP_W'(1);
            adv_phase[i] = phase_q[i];
            adv_wrap[i]  = 1'b0;
            if (slip_q[i] == SLIP_W'(9)) begin
                adv_slip[i]  = '0;
                adv_phase[i] = phase_q[i] + PHASE_W'(1);
                adv_wrap[i]  = (phase_q[i] == {PHASE_W{1'b1}});
            end
        end
    end

    // Per-channel FSM next state and counter updates.
    always_comb begin
        locked_d = ch_locked;
        fail_d   = sweep_fail;
        for (int i = 0; i < int'(NCH); i++) begin
            state_d[i] = state_q[i];
            set_d[i]   = set_q[i];
            win_d[i]   = win_q[i];
            tok_d[i]   = tok_q[i];
            loss_d[i]  = loss_q[i];
            phase_d[i] = phase_q[i];
            slip_d[i]  = slip_q[i];
            tok_nx[i]  = tok_q[i];
            if (is_tok(aligned_q[i]) && (tok_q[i] < TOK_W'(MIN_TOK))) begin
                tok_nx[i] = tok_q[i] + TOK_W'(1);
            end

            if (!en) begin
                state_d[i]  = IDLE;
                set_d[i]    = '0;
                win_d[i]    = '0;
                tok_d[i]    = '0;
                loss_d[i]   = '0;
                locked_d[i] = 1'b0;
            end else if (restart) begin
                state_d[i]  = SETTLE;
                set_d[i]    = '0;
                win_d[i]    = '0;
                tok_d[i]    = '0;
                loss_d[i]   = '0;
                phase_d[i]  = '0;
                slip_d[i]   = '0;
                locked_d[i] = 1'b0;
                fail_d[i]   = 1'b0;
            end else begin
                case (state_q[i])
                    IDLE: begin
                        state_d[i] = SETTLE;
                        set_d[i]   = '0;
                    end
                    SETTLE: begin
                        if (set_q[i] == SET_W'(SETTLE_CYC - 1)) begin
                            state_d[i] = SEARCH;
                            set_d[i]   = '0;
                            win_d[i]   = '0;
                            tok_d[i]   = '0;
                        end else begin
                            set_d[i] = set_q[i] + SET_W'(1);
                        end
                    end
                    SEARCH: begin
                        if (win_q[i] == WIN_W'(WIN_LEN - 1)) begin
                            win_d[i] = '0;
                            tok_d[i] = '0;
                            if (tok_nx[i] >= TOK_W'(MIN_TOK)) begin
                                state_d[i]  = LOCKED;
                                loss_d[i]   = '0;
                                locked_d[i] = 1'b1;
                            end else begin
                                state_d[i] = SETTLE;
                                set_d[i]   = '0;
                                phase_d[i] = adv_phase[i];
                                slip_d[i]  = adv_slip[i];
                                if (adv_wrap[i]) begin
                                    fail_d[i] = 1'b1;
                                end
                            end
                        end else begin
                            win_d[i] = win_q[i] + WIN_W'(1);
                            tok_d[i] = tok_nx[i];
                        end
                    end
                    LOCKED: begin
                        if (win_q[i] == WIN_W'(WIN_LEN - 1)) begin
                            win_d[i] = '0;
                            tok_d[i] = '0;
                            if (tok_nx[i] != '0) begin
                                loss_d[i] = '0;
                            end else if ((loss_q[i] + LOSS_W'(1)) >= LOSS_W'(LOSS_WIN)) begin
                                state_d[i]  = SETTLE;
                                set_d[i]    = '0;
                                loss_d[i]   = '0;
                                locked_d[i] = 1'b0;
                                phase_d[i]  = adv_phase[i];
                                slip_d[i]   = adv_slip[i];
                                if (adv_wrap[i]) begin
                                    fail_d[i] = 1'b1;
                                end
                            end else begin
                                loss_d[i] = loss_q[i] + LOSS_W'(1);
                            end
                        end else begin
                            win_d[i] = win_q[i] + WIN_W'(1);
                            tok_d[i] = tok_nx[i];
                        end
                    end
                    default: begin
                        state_d[i] = IDLE;
                    end
                endcase
            end
        end
    end

    // State, counters, datapath and output registers.
    always_ff @(posedge clkx1in or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(NCH); i++) begin
                state_q[i]    <= IDLE;
                set_q[i]      <= '0;
                win_q[i]      <= '0;
                tok_q[i]      <= '0;
                loss_q[i]     <= '0;
                phase_q[i]    <= '0;
                slip_q[i]     <= '0;
                raw_prev_q[i] <= '0;
                aligned_q[i]  <= '0;
            end
            ch_locked  <= '0;
            sweep_fail <= '0;
            all_locked <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NCH); i++) begin
                state_q[i]    <= state_d[i];
                set_q[i]      <= set_d[i];
                win_q[i]      <= win_d[i];
                tok_q[i]      <= tok_d[i];
                loss_q[i]     <= loss_d[i];
                phase_q[i]    <= phase_d[i];
                slip_q[i]     <= slip_d[i];
                raw_prev_q[i] <= rawdata[10*i +: 10];
                aligned_q[i]  <= aligned_d[i];
            end
            ch_locked  <= locked_d;
            sweep_fail <= fail_d;
            all_locked <= &locked_d;
        end
    end

endmodule

// File: tb/tb_tmds_word_align.sv
// Bench for tmds_word_align: checkpoint table, random slip model, hand-built corner sequences.
module tb_tmds_word_align;

    localparam int unsigned NCH        = 3;
    localparam int unsigned PHASE_W    = 4;
    localparam int unsigned WIN_LEN    = 128;
    localparam int unsigned MIN_TOK    = 8;
    localparam int unsigned SETTLE_CYC = 8;
    localparam int unsigned LOSS_WIN   = 2;
    localparam int          P          = int'(SETTLE_CYC + WIN_LEN);
    localparam int          NPOS       = (1 << PHASE_W) * 10;

    logic                    clk = 1'b0;
    logic                    rstn;
    logic                    en;
    logic                    restart;
    logic [NCH*10-1:0]       rawdata;
    logic [NCH*10-1:0]       aligned_data;
    logic [NCH*PHASE_W-1:0]  phasel;
    logic [NCH-1:0]          ch_locked;
    logic                    all_locked;
    logic [NCH-1:0]          sweep_fail;

    always #5 clk = ~clk;

    tmds_word_align #(
        .NCH(NCH), .PHASE_W(PHASE_W), .WIN_LEN(WIN_LEN), .MIN_TOK(MIN_TOK),
        .SETTLE_CYC(SETTLE_CYC), .LOSS_WIN(LOSS_WIN)
    ) dut (
        .clkx1in(clk), .rstn(rstn), .en(en), .restart(restart), .rawdata(rawdata),
        .aligned_data(aligned_data), .phasel(phasel), .ch_locked(ch_locked),
        .all_locked(all_locked), .sweep_fail(sweep_fail)
    );

    typedef struct {
        int          o;
        logic [2:0]  lk;
        logic [2:0]  fl;
        logic [3:0]  ph2;
    } cp_t;

    cp_t         cps [10];
    logic [9:0]  toks [4];
    int          mode  [NCH];   // 0 token stream, 1 all zeros, 2 random non-token words
    int          shift [NCH];   // bit offset of the channel's framing
    logic [9:0]  w_cur [NCH];
    logic [9:0]  w_prev[NCH];
    logic [9:0]  r_cur [NCH];
    logic [9:0]  r_prev[NCH];
    int          k;
    int          o;
    int          n_chk;
    int          n_pass;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, k);
    endtask

    function automatic logic is_tok(input logic [9:0] w);
        logic hit;
        hit = 1'b0;
        for (int t = 0; t < 4; t++) if (w == toks[t]) hit = 1'b1;
        return hit;
    endfunction

    function automatic logic [9:0] gen_word(input int ch, input int kk);
        logic [9:0] v;
        v = '0;
        if (mode[ch] == 0) begin
            if (kk % 8 == 0) v = (ch == 1) ? toks[0] : toks[(kk / 8) % 4];
        end else if (mode[ch] == 2) begin
            v = 10'($urandom);
            while (is_tok(v)) v = 10'($urandom);
        end
        return v;
    endfunction

    // Expected phase of a channel that has never locked since the restart at o=1.
    function automatic int sweep_phase(input int oo);
        return (((oo - 1) / P) % NPOS) / 10;
    endfunction

    // One clock: build the framed raw words, advance, sample 1 time unit after the edge.
    task automatic tick();
        logic [19:0] cat;
        logic [9:0]  wn;
        for (int ch = 0; ch < int'(NCH); ch++) begin
            wn  = gen_word(ch, k + 1);
            cat = {wn, w_cur[ch]};
            w_prev[ch] = w_cur[ch];
            w_cur[ch]  = wn;
            r_prev[ch] = r_cur[ch];
            r_cur[ch]  = 10'(cat >> (10 - shift[ch]));
            rawdata[10*ch +: 10] = r_cur[ch];
        end
        @(posedge clk);
        k++;
        o++;
        #1;
    endtask

    task automatic run_to(input int target);
        while (o < target) tick();
    endtask

    task automatic do_restart();
        restart = 1'b1;
        o = 0;
        tick();
        restart = 1'b0;
    endtask

    int  o_stop;
    int  o_drop;
    int  ph_exp;
    logic found;
    logic [9:0] exp_w;

    initial begin
        toks[0] = 10'b1101010100;
        toks[1] = 10'b0010101011;
        toks[2] = 10'b0101010100;
        toks[3] = 10'b1010101011;
        cps[0] = '{136,   3'b000, 3'b000, 4'd0};
        cps[1] = '{137,   3'b001, 3'b000, 4'd0};
        cps[2] = '{544,   3'b001, 3'b000, 4'd0};
        cps[3] = '{545,   3'b011, 3'b000, 4'd0};
        cps[4] = '{1360,  3'b011, 3'b000, 4'd0};
        cps[5] = '{1361,  3'b011, 3'b000, 4'd1};
        cps[6] = '{9521,  3'b011, 3'b000, 4'd7};
        cps[7] = '{21760, 3'b011, 3'b000, 4'd15};
        cps[8] = '{21761, 3'b011, 3'b100, 4'd0};
        cps[9] = '{21762, 3'b011, 3'b100, 4'd0};
        n_chk = 0; n_pass = 0; k = 0; o = 0;
        for (int ch = 0; ch < int'(NCH); ch++) begin
            mode[ch] = 1; shift[ch] = 0;
            w_cur[ch] = '0; w_prev[ch] = '0; r_cur[ch] = '0; r_prev[ch] = '0;
        end

        // Reset: outputs held at zero even with live input data.
        rstn = 1'b0; en = 1'b1; restart = 1'b0; rawdata = 30'h2AB_CDEF1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_aligned", aligned_data, '0);
        check("rst_phasel", phasel, '0);
        check("rst_locked", {all_locked, ch_locked}, '0);
        check("rst_fail", sweep_fail, '0);
        rawdata = '0; en = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        tick(); tick();
        check("idle_locked", ch_locked, '0);

        // Random words: aligned output vs slip model (slip 0 for the first window, then 1).
        for (int ch = 0; ch < int'(NCH); ch++) mode[ch] = 2;
        en = 1'b1;
        o = 0;
        for (int c = 0; c < 2 * P + 1; c++) begin
            tick();
            for (int ch = 0; ch < int'(NCH); ch++) begin
                exp_w = 10'({r_cur[ch], r_prev[ch]} >> ((o >= P + 2) ? 1 : 0));
                check($sformatf("rand_aligned_ch%0d", ch), aligned_data[10*ch +: 10], exp_w);
            end
        end

        // All channels at offset 0: all_locked exactly after settle + one window + 1.
        for (int ch = 0; ch < int'(NCH); ch++) begin mode[ch] = 0; shift[ch] = 0; end
        do_restart();
        check("restart_clears_lock", ch_locked, '0);
        run_to(P);
        check("all_locked_early", all_locked, 1'b0);
        run_to(P + 1);
        check("all_locked_on_time", all_locked, 1'b1);
        check("all_locked_phasel", phasel, '0);

        // Checkpoint table: ch0 aligned, ch1 shifted by 3, ch2 never carries tokens.
        mode[0] = 0; shift[0] = 0;
        mode[1] = 0; shift[1] = 3;
        mode[2] = 1; shift[2] = 0;
        do_restart();
        for (int j = 0; j < 10; j++) begin
            run_to(cps[j].o);
            check($sformatf("cp%0d_locked", j), ch_locked, cps[j].lk);
            check($sformatf("cp%0d_all", j), all_locked, &cps[j].lk);
            check($sformatf("cp%0d_fail", j), sweep_fail, cps[j].fl);
            check($sformatf("cp%0d_phasel", j), phasel, {cps[j].ph2, 8'h00});
        end

        // Slipped channel delivers the original framing, tokens included.
        for (int c = 0; c < 16; c++) begin
            tick();
            check("ch1_aligned", aligned_data[19:10], w_prev[1]);
        end

        // Lock loss on ch0: drop on a window boundary, then relock one position later.
        mode[0] = 1;
        o_stop = o;
        found = 1'b0;
        o_drop = 0;
        for (int c = 0; c < 4 * int'(WIN_LEN) && !found; c++) begin
            tick();
            if (ch_locked[0] == 1'b0) begin found = 1'b1; o_drop = o; end
        end
        check("lockloss_seen", found, 1'b1);
        check("lockloss_boundary", 64'((o_drop - (P + 1)) % int'(WIN_LEN)), 64'(0));
        check("lockloss_not_early", (o_drop - o_stop) > int'(WIN_LEN), 1'b1);
        mode[0] = 0; shift[0] = 1;
        run_to(o_drop + P - 1);
        check("relock_early", ch_locked[0], 1'b0);
        check("relock_phase0", phasel[3:0], 4'd0);
        run_to(o_drop + P);
        check("relock_slip1", ch_locked[0], 1'b1);

        // en=0 beats restart; phase and sweep_fail retained while idle.
        ph_exp = sweep_phase(o);
        en = 1'b0; restart = 1'b1;
        tick();
        restart = 1'b0;
        check("prio_locked", {all_locked, ch_locked}, '0);
        check("prio_fail", sweep_fail, 3'b100);
        check("prio_phasel", phasel, {4'(ph_exp), 8'h00});
        repeat (150) tick();
        check("idle_hold_locked", ch_locked, '0);
        check("idle_hold_phasel", phasel, {4'(ph_exp), 8'h00});
        check("idle_hold_fail", sweep_fail, 3'b100);
        for (int ch = 0; ch < int'(NCH); ch++) shift[ch] = 0;
        mode[0] = 0; mode[1] = 0; mode[2] = 1;
        en = 1'b1;
        do_restart();
        check("restart_fail_clr", sweep_fail, '0);
        check("restart_phasel", phasel, '0);

        // Asynchronous reset between edges while ch2 is still searching.
        run_to(150);
        check("pre_rst_locked", ch_locked, 3'b011);
        #3 rstn = 1'b0;
        #1;
        check("arst_aligned", aligned_data, '0);
        check("arst_locked", {all_locked, ch_locked}, '0);
        check("arst_phasel", phasel, '0);
        check("arst_fail", sweep_fail, '0);
        @(negedge clk);
        rstn = 1'b1;
        en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
